// File: rtl/io_bank_cfg_if.sv
// Programming-chain bundle for the I/O bank.
// Master drives the shift/commit strobes; slave returns chain tail and status.
interface io_bank_cfg_if;
  logic prog_en;
  logic prog_in;
  logic prog_commit;
  logic prog_out;
  logic cfg_valid;
  logic cfg_error;

  modport master (
    output prog_en, prog_in, prog_commit,
    input  prog_out, cfg_valid, cfg_error
  );

  modport slave (
    input  prog_en, prog_in, prog_commit,
    output prog_out, cfg_valid, cfg_error
  );
endinterface

// File: rtl/io_bank_cfg.sv
// Programmable I/O bank: serial shadow config, framed atomic commit,
// per-pad OFF/IN/OUT/open-drain modes with inversion and synchronisers.
module io_bank_cfg #(
  parameter int NUM_IO      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               prog_clk,
  input  logic               prog_rst_n,
  io_bank_cfg_if.slave       bus,
  inout  wire [NUM_IO-1:0]   fpga,
  inout  wire [NUM_IO-1:0]   io_pad
);

  localparam int FRAME = 3 * NUM_IO;
  localparam int CW    = $clog2(FRAME + 2);
  localparam logic [CW-1:0] FULL = CW'(FRAME);
  localparam logic [CW-1:0] SAT  = CW'(FRAME + 1);

  typedef enum logic [1:0] {
    M_OFF = 2'b00,
    M_IN  = 2'b01,
    M_OUT = 2'b10,
    M_OD  = 2'b11
  } mode_t;

  logic [FRAME-1:0] shadow;
  logic [FRAME-1:0] active;
  logic [CW-1:0]    cnt;
  logic             commit;
  logic             accept;

  assign commit = bus.prog_commit & ~bus.prog_en;
  assign accept = commit & (cnt == FULL);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shadow        <= '0;
      active        <= '0;
      cnt           <= '0;
      bus.prog_out  <= 1'b0;
      bus.cfg_valid <= 1'b0;
      bus.cfg_error <= 1'b0;
    end else begin
      unique case (1'b1)
        bus.prog_en: begin
          shadow       <= {shadow[FRAME-2:0], bus.prog_in};
          bus.prog_out <= shadow[FRAME-1];
          if (cnt != SAT) cnt <= cnt + 1'b1;
        end
        commit: begin
          cnt <= '0;
          if (cnt == FULL) begin
            active        <= shadow;
            bus.cfg_valid <= 1'b1;
            bus.cfg_error <= 1'b0;
          end else begin
            bus.cfg_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    mode_t                  mode;
    mode_t                  next_mode;
    logic                   inv;
    logic                   clr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   out_q;

    assign mode      = mode_t'(active[3*i +: 2]);
    assign next_mode = mode_t'(shadow[3*i +: 2]);
    assign inv       = active[3*i+2];
    assign clr       = accept && (next_mode != mode);

    // A direction change flushes both paths so nothing stale escapes.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
        sync_q <= '0;
        out_q  <= 1'b0;
      end else if (clr) begin
        sync_q <= '0;
        out_q  <= 1'b0;
      end else begin
        if (mode == M_IN)
          sync_q <= (sync_q << 1) | SYNC_STAGES'(io_pad[i] ^ inv);
        if (mode == M_OUT || mode == M_OD)
          out_q <= fpga[i] ^ inv;
      end
    end

    assign fpga[i]   = (mode == M_IN) ? sync_q[SYNC_STAGES-1] : 1'bz;
    assign io_pad[i] = (mode == M_OUT)           ? out_q :
                       (mode == M_OD && !out_q)  ? 1'b0  : 1'bz;
  end

endmodule

// File: tb/tb_io_bank_cfg.sv
// Directed bench for io_bank_cfg with NUM_IO=4: frame loads, pad
// datapaths, frame-length errors, readback and asynchronous reset.
module tb_io_bank_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_bank_cfg_if bus();

  logic [3:0] fv, fe, pv, pe;
  wire  [3:0] fpga;
  wire  [3:0] io_pad;

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign fpga[i]   = fe[i] ? fv[i] : 1'bz;
    assign io_pad[i] = pe[i] ? pv[i] : 1'bz;
  end

  io_bank_cfg #(
    .NUM_IO      (4),
    .SYNC_STAGES (2)
  ) dut (
    .prog_clk   (clk),
    .prog_rst_n (rst_n),
    .bus        (bus),
    .fpga       (fpga),
    .io_pad     (io_pad)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          nbits;
    logic [31:0] bits;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_pad1;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic z_pad(input string nm, input int i);
    logic se, sv;
    se = pe[i];
    sv = pv[i];
    pe[i] = 1'b1;
    pv[i] = 1'b0;
    #1 chk({nm, " lo"}, io_pad[i], 1'b0);
    pv[i] = 1'b1;
    #1 chk({nm, " hi"}, io_pad[i], 1'b1);
    pe[i] = se;
    pv[i] = sv;
  endtask

  task automatic z_fpga(input string nm, input int i);
    logic se, sv;
    se = fe[i];
    sv = fv[i];
    fe[i] = 1'b1;
    fv[i] = 1'b0;
    #1 chk({nm, " lo"}, fpga[i], 1'b0);
    fv[i] = 1'b1;
    #1 chk({nm, " hi"}, fpga[i], 1'b1);
    fe[i] = se;
    fv[i] = sv;
  endtask

  task automatic shift(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      bus.prog_en = 1'b1;
      bus.prog_in = bits[k];
      tick();
    end
    bus.prog_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.prog_commit = 1'b1;
    tick();
    bus.prog_commit = 1'b0;
  endtask

  logic [11:0] fa, fb;

  initial begin
    tbl[0] = '{"short11", 11, 32'h0000_05A5, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{"long13",  13, 32'h0000_1ABC, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{"sat28",   28, 32'h0ACE_10D1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{"exact12", 12, 32'h0000_00D1, 1'b1, 1'b0, 1'b0};
    fa = 12'h0D1;
    fb = 12'h0D2;

    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
    bus.prog_commit = 1'b0;
    fe = '0; fv = '0; pe = '0; pv = '0;

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst prog_out", bus.prog_out, 1'b0);
    chk("rst cfg_valid", bus.cfg_valid, 1'b0);
    chk("rst cfg_error", bus.cfg_error, 1'b0);
    for (int i = 0; i < 4; i++) begin
      z_pad($sformatf("rst io_pad%0d z", i), i);
      z_fpga($sformatf("rst fpga%0d z", i), i);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // frame A: pad2 OD, pad1 OUT, pad0 IN
    fe = 4'b0110; fv = '0; pe = 4'b0001; pv = '0;
    shift({20'h0, fa}, 12);
    do_commit();
    chk("A cfg_valid", bus.cfg_valid, 1'b1);
    chk("A cfg_error", bus.cfg_error, 1'b0);
    pv[0] = 1'b1;
    fv[1] = 1'b1;
    fv[2] = 1'b0;
    #1 chk("A out1 cleared", io_pad[1], 1'b0);
    tick();
    chk("A in0 lat1", fpga[0], 1'b0);
    chk("A out1 lat1", io_pad[1], 1'b1);
    chk("A od2 low", io_pad[2], 1'b0);
    tick();
    chk("A in0 lat2", fpga[0], 1'b1);
    fv[2] = 1'b1;
    tick();
    z_pad("A od2 rel", 2);
    z_pad("A off3 pad", 3);
    z_fpga("A off3 fpga", 3);

    // frame C: pad1 inverted output
    shift(32'h0F1, 12);
    do_commit();
    chk("C cfg_valid", bus.cfg_valid, 1'b1);
    tick();
    chk("C out1 inv", io_pad[1], 1'b0);

    // frame length table
    foreach (tbl[r]) begin
      shift(tbl[r].bits, tbl[r].nbits);
      do_commit();
      chk({tbl[r].name, " valid"}, bus.cfg_valid, tbl[r].exp_valid);
      chk({tbl[r].name, " error"}, bus.cfg_error, tbl[r].exp_err);
      fv[1] = 1'b0;
      tick();
      chk({tbl[r].name, " pad1"}, io_pad[1], tbl[r].exp_pad1);
      fv[1] = 1'b1;
    end

    // readback of A while B loads; commit during shift ignored
    for (int k = 0; k < 12; k++) begin
      bus.prog_en = 1'b1;
      bus.prog_in = fb[11-k];
      bus.prog_commit = (k == 5);
      tick();
      chk($sformatf("rb bit%0d", k), bus.prog_out, fa[11-k]);
    end
    bus.prog_en = 1'b0;
    bus.prog_commit = 1'b0;
    chk("B pre err", bus.cfg_error, 1'b0);
    chk("B pre in0", fpga[0], 1'b1);
    chk("B pre out1", io_pad[1], 1'b1);
    do_commit();
    chk("B valid", bus.cfg_valid, 1'b1);
    chk("B error", bus.cfg_error, 1'b0);
    pe[0] = 1'b0;
    fe[0] = 1'b1;
    fv[0] = 1'b1;
    #1 chk("B out0 cleared", io_pad[0], 1'b0);
    tick();
    chk("B out0 lat1", io_pad[0], 1'b1);
    z_fpga("B fpga0 rel", 0);

    // async reset mid-frame
    tick();
    bus.prog_en = 1'b1;
    bus.prog_in = 1'b1;
    tick();
    tick();
    bus.prog_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst valid", bus.cfg_valid, 1'b0);
    chk("arst prog_out", bus.prog_out, 1'b0);
    chk("arst error", bus.cfg_error, 1'b0);
    z_pad("arst pad1", 1);
    z_pad("arst pad0", 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_commit();
    chk("arst commit err", bus.cfg_error, 1'b1);
    chk("arst commit valid", bus.cfg_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
